// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save (sum, carry) pair into binary, CHUNK bits per clock
module csa_resolver #(
  parameter int WIDTH = 4,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
);

  localparam int N  = (WIDTH + 1) / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic             c_q, c_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH+1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;

  always_comb begin
    a_slice   = a_q[idx_q*CHUNK +: CHUNK];
    b_slice   = b_q[idx_q*CHUNK +: CHUNK];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, c_q};

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    idx_d       = idx_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Carry bits carry weight 2^(i+1), so B is the carry vector shifted up one.
          a_d      = {1'b0, sum_vec};
          b_d      = {carry_vec, 1'b0};
          c_d      = 1'b0;
          idx_d    = '0;
          result_d = '0;
          state_d  = ADD;
        end
      end
      ADD: begin
        result_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        c_d = slice_sum[CHUNK];
        if (idx_q == IW'(N - 1)) begin
          result_d[WIDTH+1] = slice_sum[CHUNK];
          out_valid_d       = 1'b1;
          state_d           = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - checks csa_resolver (4/1 and 7/2 builds) against a slice-count model
module tb_csa_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] in_valid, out_ready, in_ready, out_valid;
  logic [7:0] sv [2];
  logic [7:0] cv [2];
  longint     tot_in [2];
  logic [5:0] r0;
  logic [8:0] r1;
  logic [3:0] s0, c0;
  logic [6:0] s1, c1;

  assign s0 = sv[0][3:0];
  assign c0 = cv[0][3:0];
  assign s1 = sv[1][6:0];
  assign c1 = cv[1][6:0];

  csa_resolver #(.WIDTH(4), .CHUNK(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sum_vec(s0), .carry_vec(c0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(r0));

  csa_resolver #(.WIDTH(7), .CHUNK(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sum_vec(s1), .carry_vec(c1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(r1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nslc(input int k);
    return (k == 1) ? 4 : 5;
  endfunction

  function automatic int chk(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic longint get_res(input int k);
    return (k == 1) ? longint'(r1) : longint'(r0);
  endfunction

  // Model: after s slices the low s*CHUNK bits of the true sum are visible.
  bit     m_busy [2];
  bit     m_valid [2];
  int     m_sl [2];
  longint m_exp [2];
  longint m_res [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0; m_valid[k] <= 1'b0; m_sl[k] <= 0; m_exp[k] <= 0; m_res[k] <= 0;
      end else if (!m_busy[k]) begin
        if (in_valid[k]) begin
          m_busy[k] <= 1'b1;
          m_sl[k]   <= 0;
          m_exp[k]  <= longint'(sv[k]) + 2 * longint'(cv[k]);
          m_res[k]  <= 0;
        end
      end else if (!m_valid[k]) begin
        m_sl[k] <= m_sl[k] + 1;
        if (m_sl[k] + 1 == nslc(k)) begin
          m_valid[k] <= 1'b1;
          m_res[k]   <= m_exp[k];
        end else begin
          m_res[k] <= m_exp[k] % (longint'(1) << ((m_sl[k] + 1) * chk(k)));
        end
      end else if (out_ready[k]) begin
        m_busy[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
      end
    end
  end

  longint sbq [2][$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq[0].delete();
      sbq[1].delete();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("in_ready%0d", k), longint'(in_ready[k]), longint'(!m_busy[k]));
      check($sformatf("out_valid%0d", k), longint'(out_valid[k]), longint'(m_valid[k]));
      check($sformatf("result%0d", k), get_res(k), m_res[k]);
      if (rst_n) begin
        if (in_valid[k] && in_ready[k]) sbq[k].push_back(tot_in[k]);
        if (out_valid[k] && out_ready[k]) begin
          if (sbq[k].size() == 0) check($sformatf("dup%0d", k), 1, 0);
          else check($sformatf("sb_sum%0d", k), get_res(k), sbq[k].pop_front());
        end
      end
    end
  end

  task automatic set_in(input int k, input longint s, input longint c, input longint t);
    sv[k] = 8'(s);
    cv[k] = 8'(c);
    tot_in[k] = t;
  endtask

  task automatic run_pair(input int k, input longint s, input longint c,
                          input int exp_lat, input longint exp_res);
    int lat;
    bit got;
    @(posedge clk); #1;
    set_in(k, s, c, s + 2 * c);
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (out_valid[k]) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check($sformatf("latency%0d", k), lat, exp_lat);
    check($sformatf("lit_res%0d", k), get_res(k), exp_res);
    check($sformatf("model_res%0d", k), m_res[k], exp_res);
  endtask

  initial begin
    int sent [2];
    bit acc [2];
    int cyc;
    int w, a, b, x, mask;

    rst_n = 1'b0;
    in_valid = 2'b00;
    out_ready = 2'b11;
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 2'($urandom_range(0, 3));
      set_in(0, $urandom_range(0, 15), $urandom_range(0, 15), 0);
      @(negedge clk);
      check("rst_out_valid", longint'(out_valid[0]), 0);
      check("rst_result", longint'(r0), 0);
      check("rst_in_ready", longint'(in_ready[0]), 1);
    end
    @(posedge clk); #1;
    in_valid = 2'b00;
    rst_n = 1'b1;

    run_pair(0, 0, 0, 5, 0);
    run_pair(0, 15, 15, 5, 45);
    run_pair(0, 1, 7, 5, 15);
    run_pair(0, 15, 8, 5, 31);
    run_pair(1, 127, 127, 4, 381);

    // Backpressure: result held, extra in_valid ignored while DONE.
    out_ready[0] = 1'b0;
    run_pair(0, 5, 3, 5, 11);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_in(0, 9, 9, 27);
      in_valid[0] = 1'b1;
      @(negedge clk);
      check("bp_result", longint'(r0), 11);
      check("bp_out_valid", longint'(out_valid[0]), 1);
      check("bp_in_ready", longint'(in_ready[0]), 0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", longint'(out_valid[0]), 0);
    check("bp_release_ready", longint'(in_ready[0]), 1);

    // Reset two edges into an operation discards it.
    @(posedge clk); #1;
    set_in(0, 15, 15, 45);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_valid", longint'(out_valid[0]), 0);
      check("mid_rst_result", longint'(r0), 0);
      check("mid_rst_ready", longint'(in_ready[0]), 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pair(0, 6, 5, 5, 16);

    // Random end-to-end through a bench-side 3:2 compressor.
    sent[0] = 0; sent[1] = 0;
    cyc = 0;
    while ((sent[0] < 200 || sent[1] < 200 || m_busy[0] || m_busy[1]) && cyc < 20000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) acc[k] = in_valid[k] && in_ready[k];
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          sent[k]++;
          in_valid[k] = 1'b0;
        end
        if (!in_valid[k] && sent[k] < 200 && $urandom_range(0, 3) != 0) begin
          w = (k == 1) ? 7 : 4;
          mask = (1 << w) - 1;
          a = int'($urandom) & mask;
          b = int'($urandom) & mask;
          x = int'($urandom) & mask;
          set_in(k, a ^ b ^ x, (a & b) | (a & x) | (b & x), a + b + x);
          in_valid[k] = 1'b1;
        end
        out_ready[k] = 1'($urandom_range(0, 1));
      end
    end
    out_ready = 2'b11;
    in_valid = 2'b00;
    check("random_timeout", longint'(cyc < 20000), 1);
    @(posedge clk);
    @(negedge clk);
    check("lost0", sbq[0].size(), 0);
    check("lost1", sbq[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate stage that sits downstream of the carry-save adder array. It accepts one redundant (sum vector, carry vector) pair and resolves it into a single binary result by rippling CHUNK bit positions per clock. Valid/ready handshakes on both sides let it sit between a CSA tree and any binary consumer without a wide single-cycle adder.

## Interface
- WIDTH, 4: width of the sum and carry vectors; must be ≥ 2.
- CHUNK, 1: bit positions resolved per ADD cycle; must divide WIDTH+1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sum_vec/carry_vec are valid.
- in_ready  output  1  block can accept a pair; equals (state == IDLE).
- sum_vec  input  WIDTH  sum bits; bit i has weight 2^i.
- carry_vec  input  WIDTH  carry bits; bit i has weight 2^(i+1).
- out_valid  output  1  result holds a resolved value.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH+2  sum_vec + 2*carry_vec, unsigned.

## Operation
- Operands are zero-extended to WIDTH+1 bits: A = {0, sum_vec}, B = {carry_vec, 0}.
- The adder never overflows: the maximum result is 3*(2^WIDTH − 1) < 2^(WIDTH+2).
- FSM states:
  - IDLE: in_ready = 1. When in_valid is high, capture A and B, clear the internal carry c and the chunk index idx, then go to ADD.
  - ADD: each edge adds A, B and c over bit slice [idx*CHUNK +: CHUNK], writes the slice into result, updates c and increments idx. After the last slice (idx = N−1, where N = (WIDTH+1)/CHUNK), write result[WIDTH+1] = c, set out_valid and go to DONE.
  - DONE: result and out_valid are held stable. On out_valid && out_ready, clear out_valid and return to IDLE.
- in_valid is ignored outside IDLE, and input changes after capture have no effect.
- result bits not yet written are 0. result is cleared on capture.
- Async reset (rst_n low, any state, including mid-ADD or DONE) sets:
  - state = IDLE, so in_ready = 1 while reset is asserted
  - out_valid = 0, result = 0, c = 0, idx = 0
  - any in-flight operation is discarded with no output.
- Reset release is synchronous to clk. The first capture is possible on the first rising edge after rst_n goes high.

## Timing
- Accept edge T (in_valid && in_ready). out_valid rises at edge T+N, i.e. T+5 for the defaults.
- in_ready is low from T through the edge where out_valid && out_ready is seen (edge D).
- in_ready is high again after D, so the next accept is at D+1 at the earliest.
- Throughput for the defaults with out_ready tied high is one result per 7 cycles (accept, 5×ADD, DONE).
- No combinational path from in_valid to out_valid. in_ready depends only on state. out_ready affects only the next state.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with random inputs -> out_valid = 0, result = 0, in_ready = 1. Release, then present sum_vec = 0, carry_vec = 0 -> after 5 cycles out_valid = 1, result = 6'b000000.
- Max operands: sum_vec = 4'b1111, carry_vec = 4'b1111 -> out_valid at T+5, result = 45 (6'b101101).
- Carry chain: sum_vec = 4'b0001, carry_vec = 4'b0111 -> result = 15 (6'b001111). Then sum_vec = 4'b1111, carry_vec = 4'b1000 -> result = 31 (6'b011111).
- Backpressure: out_ready = 0 for 10 cycles after out_valid -> result and out_valid stay stable, in_ready = 0, and a new in_valid is ignored. Raise out_ready -> one handshake, then back to IDLE.
- Reset mid-operation: pull rst_n low at T+2 -> out_valid is never asserted for that pair and result = 0. After release, a fresh pair resolves correctly.
- Random end-to-end: 200 random a, b, x values passed through the carry-save adder, with its cout/sum fed to this block and out_ready toggled randomly -> every result equals a + b + x, and no result is lost or duplicated. Repeat with WIDTH = 7, CHUNK = 2 -> out_valid at T+4.
